// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run/step clock-enable generator for the CPU core, with debounced buttons.
// Optional feature macro: STEP_AUTOREPEAT_EN (held step button repeats in step mode).

module cpu_step_ctrl #(
  parameter int WAIT_TIME       = 13500000,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int REPEAT_CYCLES   = 6750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step_n,
  input  logic       btn_mode_n,
  output logic       step_en,
  output logic       mode,
  output logic [5:0] step_count
);

  localparam int DIV_W = $clog2(WAIT_TIME);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(WAIT_TIME - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  if (WAIT_TIME < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("cpu_step_ctrl: need WAIT_TIME >= 2, DEBOUNCE_CYCLES >= 1, REPEAT_CYCLES >= 1");
  end

  typedef enum logic {
    RUN  = 1'b0,
    STEP = 1'b1
  } state_t;

  logic [1:0] raw;
  logic [1:0] press;
  logic       press_step;
  logic       press_mode;

  assign raw = {btn_mode_n, btn_step_n};

  // Per button: 2-flop synchronizer, then a level debouncer; press = debounced falling edge.
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic            sync1;
    logic            sync2;
    logic            lvl;
    logic            lvl_d;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
        lvl   <= 1'b1;
        lvl_d <= 1'b1;
        cnt   <= '0;
      end else begin
        sync1 <= raw[i];
        sync2 <= sync1;
        lvl_d <= lvl;
        if (sync2 == lvl) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          lvl <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[i] = lvl_d & ~lvl;
  end

  assign press_step = press[0];
  assign press_mode = press[1];

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             step_next;

`ifdef STEP_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_next;
  logic             rep_arm;
  logic             rep_arm_next;
  logic             step_held;

  assign step_held = ~g_btn[0].lvl;
`endif

  always_comb begin
    state_next = state;
    div_next   = div;
    step_next  = 1'b0;
`ifdef STEP_AUTOREPEAT_EN
    rep_next     = rep;
    rep_arm_next = rep_arm;
`endif
    if (press_mode) begin
      // A toggle wins over a coincident step press or terminal count.
      state_next = (state == RUN) ? STEP : RUN;
      div_next   = '0;
`ifdef STEP_AUTOREPEAT_EN
      rep_next     = '0;
      rep_arm_next = 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (div == DIV_LAST) begin
            step_next = 1'b1;
            div_next  = '0;
          end else begin
            div_next = div + 1'b1;
          end
`ifdef STEP_AUTOREPEAT_EN
          rep_next     = '0;
          rep_arm_next = 1'b0;
`endif
        end
        STEP: begin
          div_next = '0;
          if (press_step) begin
            step_next = 1'b1;
`ifdef STEP_AUTOREPEAT_EN
            rep_next     = '0;
            rep_arm_next = 1'b1;
          end else if (!step_held) begin
            rep_next     = '0;
            rep_arm_next = 1'b0;
          end else if (rep_arm) begin
            if (rep == REP_LAST) begin
              step_next = 1'b1;
              rep_next  = '0;
            end else begin
              rep_next = rep + 1'b1;
            end
`endif
          end
        end
        default: begin
          state_next = RUN;
          div_next   = '0;
        end
      endcase
    end
  end

  // Control registers: state, divider, pulse and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      div        <= '0;
      step_en    <= 1'b0;
      step_count <= '0;
    end else begin
      state   <= state_next;
      div     <= div_next;
      step_en <= step_next;
      if (step_next) begin
        step_count <= step_count + 1'b1;
      end
    end
  end

`ifdef STEP_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rep     <= '0;
      rep_arm <= 1'b0;
    end else begin
      rep     <= rep_next;
      rep_arm <= rep_arm_next;
    end
  end
`endif

  assign mode = (state == STEP);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl with WAIT_TIME=4, DEBOUNCE_CYCLES=3, REPEAT_CYCLES=5.
// Exact-timing hand sequences followed by a table of phases checked through a scoreboard.

module tb_cpu_step_ctrl;

  localparam int WT = 4;
  localparam int DB = 3;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_step_n = 1'b1;
  logic       btn_mode_n = 1'b1;
  logic       step_en;
  logic       mode;
  logic [5:0] step_count;

  cpu_step_ctrl #(
    .WAIT_TIME      (WT),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_step_n(btn_step_n),
    .btn_mode_n(btn_mode_n),
    .step_en   (step_en),
    .mode      (mode),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic step_n;
    logic mode_n;
    int   cycles;
    int   pulses;
    logic mode;
    int   count;
  } vec_t;

  typedef struct {
    int   pulses;
    logic mode;
    int   count;
  } exp_t;

  vec_t tbl [12];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int   p;
    logic prev;

    // Phases continue from the state left by the hand sequences (STEP, count 1).
    tbl[0]  = '{1'b1, 1'b1, 10,  0, 1'b1, 1};
    tbl[1]  = '{1'b0, 1'b1, 6,   1, 1'b1, 2};
    tbl[2]  = '{1'b1, 1'b1, 6,   0, 1'b1, 2};
    tbl[3]  = '{1'b1, 1'b0, 6,   0, 1'b0, 2};
    tbl[4]  = '{1'b1, 1'b1, 6,   1, 1'b0, 3};
    tbl[5]  = '{1'b1, 1'b1, 266, 67, 1'b0, 6};
    tbl[6]  = '{1'b0, 1'b1, 6,   1, 1'b0, 7};
    tbl[7]  = '{1'b1, 1'b1, 6,   2, 1'b0, 9};
    tbl[8]  = '{1'b1, 1'b0, 6,   1, 1'b1, 10};
    tbl[9]  = '{1'b1, 1'b1, 8,   0, 1'b1, 10};
`ifdef STEP_AUTOREPEAT_EN
    tbl[10] = '{1'b0, 1'b1, 18,  3, 1'b1, 13};
    tbl[11] = '{1'b1, 1'b1, 12,  1, 1'b1, 14};
`else
    tbl[10] = '{1'b0, 1'b1, 18,  1, 1'b1, 11};
    tbl[11] = '{1'b1, 1'b1, 12,  0, 1'b1, 11};
`endif

    rst = 1'b1;
    repeat (3) tick();
    check("reset_step_en", step_en, 0);
    check("reset_mode", mode, 0);
    check("reset_count", step_count, 0);
    rst = 1'b0;

    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("run_pulse_c%0d", i), step_en, (i % 4 == 0));
    end
    check("run_count", step_count, 5);
    check("run_mode", mode, 0);

    btn_mode_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("modepress_mode_c%0d", i), mode, (i >= 6));
      check($sformatf("modepress_step_en_c%0d", i), step_en, (i == 4));
    end
    btn_mode_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("step_idle_en_c%0d", i), step_en, 0);
      check($sformatf("step_idle_mode_c%0d", i), mode, 1);
    end
    check("modepress_count", step_count, 6);

    for (int n = 0; n < 3; n++) begin
      btn_step_n = 1'b0;
      for (int i = 1; i <= 12; i++) begin
        tick();
        if (i == 6) btn_step_n = 1'b1;
        check($sformatf("press%0d_step_en_c%0d", n, i), step_en, (i == 6));
      end
    end
    check("presses_count", step_count, 9);
    check("presses_mode", mode, 1);

    btn_step_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 2) btn_step_n = 1'b1;
      check($sformatf("glitch_step_en_c%0d", i), step_en, 0);
    end
    check("glitch_count", step_count, 9);
    btn_step_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 6) btn_step_n = 1'b1;
      check($sformatf("postglitch_step_en_c%0d", i), step_en, (i == 6));
    end
    check("postglitch_count", step_count, 10);

    btn_step_n = 1'b0;
    btn_mode_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 6) begin
        btn_step_n = 1'b1;
        btn_mode_n = 1'b1;
      end
      check($sformatf("simul_mode_c%0d", i), mode, (i < 6));
      check($sformatf("simul_step_en_c%0d", i), step_en, (i == 10));
    end
    check("simul_count", step_count, 11);

    btn_mode_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) rst = 1'b1;
      if (i == 4) begin
        check("midreset_step_en", step_en, 0);
        check("midreset_mode", mode, 0);
        check("midreset_count", step_count, 0);
        rst = 1'b0;
      end
      if (i >= 5) begin
        check($sformatf("rehold_mode_c%0d", i), mode, (i >= 10));
        check($sformatf("rehold_step_en_c%0d", i), step_en, (i == 8));
      end
    end
    btn_mode_n = 1'b1;
    check("rehold_count", step_count, 1);

    prev = step_en;
    for (int r = 0; r < 12; r++) begin
      btn_step_n = tbl[r].step_n;
      btn_mode_n = tbl[r].mode_n;
      sb.push_back('{tbl[r].pulses, tbl[r].mode, tbl[r].count});
      p = 0;
      for (int c = 0; c < tbl[r].cycles; c++) begin
        tick();
        if (step_en === 1'b1) p++;
        if (step_en === 1'b1 && prev === 1'b1) begin
          check($sformatf("row%0d_back_to_back_c%0d", r, c), {step_en, prev}, 2'b01);
        end
        prev = step_en;
      end
      e = sb.pop_front();
      check($sformatf("row%0d_pulses", r), p, e.pulses);
      check($sformatf("row%0d_mode", r), mode, e.mode);
      check($sformatf("row%0d_count", r), step_count, e.count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
